instr_fetch_mem: RTL and testbench
==================================

# instr_fetch_mem

Parametrised, byte-addressed instruction memory with a registered valid/ready fetch interface, fault reporting, and a word-wide program-load port. It sits between the PC/fetch stage and decode. It returns one little-endian 32-bit instruction per accepted request with a one-cycle latency, and it holds the response under back-pressure. The load port lets the testbench or a boot loader write program words at run time.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words stored. Power of two, at least 4.
- ADDR_WIDTH, 32: width of the byte address on both fetch and load ports.
- NOP_INSTR, 32'h00000013: word returned on a fault and held on rsp_instr at reset.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  a fetch request is present.
- req_ready  out  1  the block accepts a request this cycle.
- req_addr  in  ADDR_WIDTH  byte address of the instruction.
- rsp_valid  out  1  rsp_instr and rsp_fault are valid.
- rsp_ready  in  1  the consumer takes the response this cycle.
- rsp_instr  out  32  fetched instruction word; byte at addr+0 goes to bits [7:0].
- rsp_fault  out  2  bit0 = misaligned, bit1 = out of range.
- load_en  in  1  write load_data to load_addr this cycle.
- load_addr  in  ADDR_WIDTH  byte address of the word to write.
- load_data  in  32  little-endian word to store.

## Operation
- Storage is DEPTH_WORDS × 32 bits. The word index is addr[log2(DEPTH_WORDS)+1:2].
- Reset does not clear storage contents.
- req_ready = !load_en && (!rsp_valid || rsp_ready).
- Load has priority. While load_en is high, no fetch is accepted.
- A request is accepted when req_valid && req_ready. The response register then loads:
  - rsp_fault[0] = (req_addr[1:0] != 0).
  - rsp_fault[1] = (req_addr >= 4·DEPTH_WORDS).
  - rsp_instr = NOP_INSTR if either fault bit is set; otherwise the stored word.
- Output register states:
  - EMPTY: rsp_valid = 0.
  - FULL: rsp_valid = 1.
- State transitions:
  - EMPTY goes to FULL on an accept.
  - FULL stays FULL on accept && rsp_ready; the register is overwritten with the new response.
  - FULL goes to EMPTY on rsp_ready && !accept.
  - FULL holds when !rsp_ready; rsp_instr and rsp_fault stay stable.
- Load write:
  - Happens when load_en && load_addr[1:0] == 0 && load_addr < 4·DEPTH_WORDS.
  - Misaligned or out-of-range loads are dropped silently.
- A load to the word currently held in the response register does not alter the held response. A later fetch returns the new data.
- Reset mid-operation:
  - rsp_valid goes to 0 immediately (asynchronous); the pending response is lost.
  - rsp_instr = NOP_INSTR, rsp_fault = 0.
  - Storage is retained.

## Timing
- Fetch latency is 1 cycle. A request accepted at edge N appears on rsp_* after edge N.
- Throughput is one fetch per cycle while rsp_ready is held high.
- Load write takes effect at the edge where load_en is high. A fetch accepted the next cycle returns the new word.
- req_ready is combinational from load_en, rsp_valid and rsp_ready. There is no combinational path from req_* to rsp_*.
- Outputs after reset are rsp_valid = 0, rsp_instr = NOP_INSTR, rsp_fault = 2'b00. req_ready is then 1 if load_en = 0.

## Configuration
- IMEM_BOOT_PROGRAM_EN defined: at time zero, words 0–3 hold 32'h00500093, 32'h00A00113, 32'h002081B3 and 32'h0000006F. All other words hold NOP_INSTR.
- IMEM_BOOT_PROGRAM_EN undefined: every word initialises to NOP_INSTR.
- Interface and timing are identical in both builds.

## Test plan
- Boot program (with IMEM_BOOT_PROGRAM_EN), rsp_ready = 1: fetch addresses 0, 4, 8, 12 on consecutive cycles -> responses 0x00500093, 0x00A00113, 0x002081B3, 0x0000006F on consecutive cycles, all with fault 0.
- Back-pressure:
  - Fetch 0 then 4 with rsp_ready = 0 for 3 cycles -> rsp_instr holds 0x00500093 and req_ready = 0 for those cycles.
  - Raise rsp_ready -> 0x00A00113 follows with no bubble.
- Faults:
  - Fetch 0x2 -> NOP, fault = 01.
  - Fetch 4·DEPTH_WORDS -> NOP, fault = 10.
  - Fetch 4·DEPTH_WORDS+1 -> NOP, fault = 11.
- Load then fetch:
  - load_en with load_addr = 0x10 and load_data = 0xDEADBEEF -> req_ready = 0 that cycle.
  - Next-cycle fetch 0x10 -> 0xDEADBEEF.
  - A load to 0x11 is dropped; fetching 0x10 still returns 0xDEADBEEF.
- Reset mid-operation:
  - Assert reset while rsp_valid = 1 between edges -> rsp_valid = 0 and rsp_instr = NOP immediately.
  - After release, fetching 0x10 still returns 0xDEADBEEF.

Source files
------------

// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: byte-addressed instruction memory with a one-deep registered
// valid/ready fetch response, fault reporting and a word-wide load port.
// Optional build macro IMEM_BOOT_PROGRAM_EN: when defined, words 0-3 power up
// with a small boot program; otherwise every word powers up as NOP_INSTR.
module instr_fetch_mem #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_instr,
    output logic [1:0]            rsp_fault,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [31:0]           load_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    // One bit wider than the address so the byte size never wraps to zero.
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(DEPTH_WORDS * 32'd4);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_e;

    // Storage is never reset; its power-up contents come from the initialiser.
`ifdef IMEM_BOOT_PROGRAM_EN
    logic [31:0] mem_q [DEPTH_WORDS] = '{0: 32'h00500093, 1: 32'h00A00113,
                                         2: 32'h002081B3, 3: 32'h0000006F,
                                         default: NOP_INSTR};
`else
    logic [31:0] mem_q [DEPTH_WORDS] = '{default: NOP_INSTR};
`endif

    state_e           state_q, state_d;
    logic [31:0]      rsp_instr_q, rsp_instr_d;
    logic [1:0]       rsp_fault_q, rsp_fault_d;

    logic             accept_s;
    logic [1:0]       req_fault_s;
    logic [IDX_W-1:0] req_idx_s;
    logic             load_we_s;
    logic [IDX_W-1:0] load_idx_s;

    // Loads take priority; a new fetch needs a free or draining response slot.
    assign req_ready = !load_en && (!rsp_valid || rsp_ready);
    assign accept_s  = req_valid && req_ready;

    assign rsp_valid = (state_q == S_FULL);
    assign rsp_instr = rsp_instr_q;
    assign rsp_fault = rsp_fault_q;

    // Decode fetch faults/index and qualify the load write.
    always_comb begin
        req_fault_s    = 2'b00;
        req_fault_s[0] = (req_addr[1:0] != 2'b00);
        req_fault_s[1] = ({1'b0, req_addr} >= MEM_BYTES);
        req_idx_s      = req_addr[IDX_W+1:2];
        load_idx_s     = load_addr[IDX_W+1:2];
        if (load_en && (load_addr[1:0] == 2'b00) && ({1'b0, load_addr} < MEM_BYTES)) begin
            load_we_s = 1'b1;
        end else begin
            load_we_s = 1'b0;
        end
    end

    // Next state of the response slot: fill on accept, drain when consumed, hold otherwise.
    always_comb begin
        state_d     = state_q;
        rsp_instr_d = rsp_instr_q;
        rsp_fault_d = rsp_fault_q;
        if (accept_s) begin
            state_d     = S_FULL;
            rsp_fault_d = req_fault_s;
            if (req_fault_s != 2'b00) begin
                rsp_instr_d = NOP_INSTR;
            end else begin
                rsp_instr_d = mem_q[req_idx_s];
            end
        end else if (rsp_ready) begin
            state_d = S_EMPTY;
        end else begin
            state_d = state_q;
        end
    end

    // Response register; reset drops any pending response immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_EMPTY;
            rsp_instr_q <= NOP_INSTR;
            rsp_fault_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            rsp_instr_q <= rsp_instr_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    // Program-load write port; storage survives reset.
    always_ff @(posedge clk) begin
        if (load_we_s) begin
            mem_q[load_idx_s] <= load_data;
        end
    end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Self-checking bench for instr_fetch_mem: directed test-plan scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_instr_fetch_mem;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [32:0] BYTES = 33'd1024;

`ifdef IMEM_BOOT_PROGRAM_EN
    localparam logic [31:0] W0 = 32'h00500093;
    localparam logic [31:0] W1 = 32'h00A00113;
    localparam logic [31:0] W2 = 32'h002081B3;
    localparam logic [31:0] W3 = 32'h0000006F;
    logic [31:0] model_mem [DEPTH] = '{0: 32'h00500093, 1: 32'h00A00113,
                                       2: 32'h002081B3, 3: 32'h0000006F,
                                       default: 32'h00000013};
`else
    localparam logic [31:0] W0 = 32'h00000013;
    localparam logic [31:0] W1 = 32'h00000013;
    localparam logic [31:0] W2 = 32'h00000013;
    localparam logic [31:0] W3 = 32'h00000013;
    logic [31:0] model_mem [DEPTH] = '{default: 32'h00000013};
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_instr;
    logic [1:0]  rsp_fault;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = 32'd0;
    logic [31:0] load_data = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_mem #(
        .DEPTH_WORDS(DEPTH),
        .ADDR_WIDTH (32),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr),
        .rsp_fault(rsp_fault),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [1:0]  exp_fault;

    wire       m_ready  = !load_en && (!exp_valid || rsp_ready);
    wire       m_accept = req_valid && m_ready;
    wire [1:0] m_fault  = {({1'b0, req_addr} >= BYTES), (req_addr[1:0] != 2'b00)};

    // Model of the response slot as seen by the consumer.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_valid <= 1'b0;
            exp_instr <= NOP;
            exp_fault <= 2'b00;
        end else if (m_accept) begin
            exp_valid <= 1'b1;
            exp_fault <= m_fault;
            exp_instr <= (m_fault != 2'b00) ? NOP : model_mem[req_addr[9:2]];
        end else if (rsp_ready) begin
            exp_valid <= 1'b0;
        end
    end

    // Model of program storage: only aligned in-range loads land.
    always @(posedge clk) begin
        if (load_en && load_addr[1:0] == 2'b00 && {1'b0, load_addr} < BYTES) begin
            model_mem[load_addr[9:2]] <= load_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            check("model_req_ready", 32'(req_ready), 32'(m_ready));
            check("model_rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            if (exp_valid) begin
                check("model_rsp_instr", rsp_instr, exp_instr);
                check("model_rsp_fault", 32'(rsp_fault), 32'(exp_fault));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic fetch(input logic [31:0] a, input logic rdy);
        req_valid = 1'b1;
        req_addr  = a;
        rsp_ready = rdy;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned k;
        k = $urandom_range(0, 9);
        if (k < 5)       return 32'($urandom_range(0, 15)) << 2;
        else if (k < 7)  return 32'($urandom_range(0, 255)) << 2;
        else if (k == 7) return 32'($urandom_range(0, 1023));
        else if (k == 8) return 32'd1024 + 32'($urandom_range(0, 64));
        else             return $urandom();
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("reset_valid", 32'(rsp_valid), 32'd0);
        check("reset_instr", rsp_instr, NOP);
        check("reset_fault", 32'(rsp_fault), 32'd0);
        check("reset_ready", 32'(req_ready), 32'd1);

        // Consecutive fetches with no back-pressure.
        fetch(32'd0, 1'b1);  step(); check("boot0", rsp_instr, W0); check("boot0_fault", 32'(rsp_fault), 32'd0);
        fetch(32'd4, 1'b1);  step(); check("boot1", rsp_instr, W1); check("boot1_valid", 32'(rsp_valid), 32'd1);
        fetch(32'd8, 1'b1);  step(); check("boot2", rsp_instr, W2);
        fetch(32'd12, 1'b1); step(); check("boot3", rsp_instr, W3); check("boot3_fault", 32'(rsp_fault), 32'd0);
        req_valid = 1'b0; step();
        check("drain_valid", 32'(rsp_valid), 32'd0);

        // Back-pressure: response held, no new accept.
        fetch(32'd0, 1'b1); step();
        fetch(32'd4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", 32'(req_ready), 32'd0);
            step();
            check("bp_hold", rsp_instr, W0);
            check("bp_valid", 32'(rsp_valid), 32'd1);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'd1);
        step();
        check("bp_next", rsp_instr, W1);
        req_valid = 1'b0; step();

        // Faults.
        fetch(32'h2, 1'b1);    step(); check("mis_instr", rsp_instr, NOP); check("mis_fault", 32'(rsp_fault), 32'd1);
        fetch(32'd1024, 1'b1); step(); check("oor_instr", rsp_instr, NOP); check("oor_fault", 32'(rsp_fault), 32'd2);
        fetch(32'd1025, 1'b1); step(); check("both_instr", rsp_instr, NOP); check("both_fault", 32'(rsp_fault), 32'd3);
        req_valid = 1'b0; step();

        // Load then fetch.
        load_en = 1'b1; load_addr = 32'h10; load_data = 32'hDEADBEEF;
        fetch(32'h10, 1'b1);
        #1;
        check("load_blocks_ready", 32'(req_ready), 32'd0);
        step();
        load_en = 1'b0;
        check("load_no_rsp", 32'(rsp_valid), 32'd0);
        step();
        check("load_fetch", rsp_instr, 32'hDEADBEEF);
        check("load_fetch_fault", 32'(rsp_fault), 32'd0);
        req_valid = 1'b0;
        load_en = 1'b1; load_addr = 32'h11; load_data = 32'h12345678;
        step();
        load_en = 1'b0;
        fetch(32'h10, 1'b1); step();
        check("drop_misaligned_load", rsp_instr, 32'hDEADBEEF);

        // Reset while a response is pending.
        req_valid = 1'b0; rsp_ready = 1'b0;
        fetch(32'd4, 1'b1); step();
        req_valid = 1'b0; rsp_ready = 1'b0;
        check("pre_reset_valid", 32'(rsp_valid), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("async_reset_valid", 32'(rsp_valid), 32'd0);
        check("async_reset_instr", rsp_instr, NOP);
        check("async_reset_fault", 32'(rsp_fault), 32'd0);
        step(); step();
        reset = 1'b0;
        fetch(32'h10, 1'b1); step();
        check("retained_after_reset", rsp_instr, 32'hDEADBEEF);
        req_valid = 1'b0; step();

        // Randomized traffic, checked every cycle by the model comparison.
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = rand_addr();
            rsp_ready = ($urandom_range(0, 9) < 7);
            load_en   = ($urandom_range(0, 7) == 0);
            load_addr = rand_addr();
            load_data = $urandom();
            if (i == 1500) begin
                #1 reset = 1'b1;
                #1;
                check("rand_reset_valid", 32'(rsp_valid), 32'd0);
                load_en = 1'b0;
                step();
                reset = 1'b0;
            end else begin
                step();
            end
        end
        req_valid = 1'b0; load_en = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
